// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider for the EX stage (div/divu).
// One quotient bit per clock; result is {remainder, quotient}, registered.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  cnt;
    logic [5:0]  cnt_nx;
    logic [64:0] work;
    logic [64:0] work_nx;
    logic [31:0] divisor;
    logic [31:0] divisor_nx;
    logic        neg_quot;
    logic        neg_quot_nx;
    logic        neg_rem;
    logic        neg_rem_nx;
    logic        ready_nx;
    logic [63:0] result_nx;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [64:0] shifted;
    logic [33:0] trial;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Magnitudes are taken only for signed requests with a negative operand.
    assign abs1 = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    assign abs2 = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

    // work = {guard, partial remainder, dividend/quotient}; the partial
    // remainder stays below the divisor, so the trial never needs more than 34 bits.
    assign shifted = {work[63:0], 1'b0};
    assign trial   = {1'b0, shifted[64:32]} - {2'b00, divisor};

    assign quot_fix = neg_quot ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem_fix  = neg_rem  ? (~work[63:32] + 32'd1) : work[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FREE: begin
                if (start && !annul) begin
                    state_nx = (opdata2 == 32'd0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: state_nx = END;
            ON: begin
                if (annul) begin
                    state_nx = FREE;
                end else if (cnt == 6'd32) begin
                    state_nx = END;
                end
            end
            END: begin
                if (!start) begin
                    state_nx = FREE;
                end
            end
            default: state_nx = FREE;
        endcase
    end

    always_comb begin
        cnt_nx      = cnt;
        work_nx     = work;
        divisor_nx  = divisor;
        neg_quot_nx = neg_quot;
        neg_rem_nx  = neg_rem;
        ready_nx    = ready;
        result_nx   = result;
        case (state)
            FREE: begin
                ready_nx  = 1'b0;
                result_nx = 64'h0;
                if (start && !annul && (opdata2 != 32'd0)) begin
                    work_nx     = {33'h0, abs1};
                    divisor_nx  = abs2;
                    neg_quot_nx = signed_div & (opdata1[31] ^ opdata2[31]);
                    neg_rem_nx  = signed_div & opdata1[31];
                    cnt_nx      = 6'd0;
                end
            end
            BY_ZERO: begin
                work_nx   = 65'h0;
                result_nx = 64'h0;
            end
            ON: begin
                if (annul) begin
                    ready_nx  = 1'b0;
                    result_nx = 64'h0;
                    cnt_nx    = 6'd0;
                end else if (cnt == 6'd32) begin
                    result_nx = {rem_fix, quot_fix};
                    ready_nx  = 1'b1;
                    cnt_nx    = 6'd0;
                end else begin
                    if (trial[33]) begin
                        work_nx = {shifted[64:1], 1'b0};
                    end else begin
                        work_nx = {1'b0, trial[31:0], shifted[31:1], 1'b1};
                    end
                    cnt_nx = cnt + 6'd1;
                end
            end
            END: begin
                if (start) begin
                    ready_nx = 1'b1;
                end else begin
                    ready_nx  = 1'b0;
                    result_nx = 64'h0;
                end
            end
            default: begin
                ready_nx  = 1'b0;
                result_nx = 64'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            work     <= 65'h0;
            divisor  <= 32'h0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            ready    <= 1'b0;
            result   <= 64'h0;
        end else begin
            cnt      <= cnt_nx;
            work     <= work_nx;
            divisor  <= divisor_nx;
            neg_quot <= neg_quot_nx;
            neg_rem  <= neg_rem_nx;
            ready    <= ready_nx;
            result   <= result_nx;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed scenarios plus randomized
// divisions checked against an arithmetic reference model.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_div dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    // Reference: 64-bit integer arithmetic, truncating division, remainder takes dividend sign.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives a request and waits (bounded) for ready; lat counts edges after acceptance.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble, output logic [63:0] res, output int lat);
        @(negedge clk);
        signed_div = sg;
        opdata1    = a;
        opdata2    = b;
        annul      = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (ready !== 1'b1 && lat < 60) begin
            if (scramble) begin
                @(negedge clk);
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Starts a division, cancels it after 'iter' iterations, and watches for a stray ready.
    task automatic annul_run(input int iter, output bit seen);
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd12345;
        opdata2    = 32'd17;
        start      = 1'b1;
        @(posedge clk);
        repeat (iter) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [63:0] res;
        int lat;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = 32'h0; opdata2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        n_checks++;
        if (result !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b0, 32'd50, 32'd3, 1'b0, res, lat);
        n_checks++;
        if (res !== model(1'b0, 32'd50, 32'd3)) begin n_fail++; $display("[TB] FAIL pre_reset_result: got %h expected %h", res, model(1'b0, 32'd50, 32'd3)); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_in_end: got ready=%b result=%h expected 0/0", ready, result); end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] res;
        int lat;
        run_div(1'b0, 32'd100, 32'd7, 1'b0, res, lat);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("[TB] FAIL divu_latency: got %0d expected 33", lat); end
        n_checks++;
        if (res !== {32'd2, 32'd14}) begin n_fail++; $display("[TB] FAIL divu_result: got %h expected %h", res, {32'd2, 32'd14}); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin n_fail++; $display("[TB] FAIL divu_hold: got ready=%b result=%h", ready, result); end
        release_start();
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin n_fail++; $display("[TB] FAIL divu_release: got ready=%b result=%h expected 0/0", ready, result); end
    endtask

    task automatic test_signed();
        logic [31:0] ca[3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] cb[3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [63:0] ce[3] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD}, {32'h0, 32'h80000000}};
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_div(1'b1, ca[i], cb[i], 1'b0, res, lat);
            n_checks++;
            if (res !== ce[i]) begin n_fail++; $display("[TB] FAIL div_signed_%0d: got %h expected %h", i, res, ce[i]); end
            n_checks++;
            if (lat !== 33) begin n_fail++; $display("[TB] FAIL div_signed_lat_%0d: got %0d expected 33", i, lat); end
            release_start();
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat;
        for (int i = 0; i < 2; i++) begin
            run_div(1'(i), $urandom, 32'd0, 1'b0, res, lat);
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("[TB] FAIL divzero_latency_%0d: got %0d expected 2", i, lat); end
            n_checks++;
            if (res !== 64'h0) begin n_fail++; $display("[TB] FAIL divzero_result_%0d: got %h expected 0", i, res); end
            release_start();
            n_checks++;
            if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL divzero_release_%0d: got %b expected 0", i, ready); end
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        bit seen;
        annul_run(15, seen);
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL annul_mid: got ready=1 expected never"); end
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, res, lat);
        n_checks++;
        if (res !== {32'h0, 32'hFFFFFFFF} || lat !== 33) begin n_fail++; $display("[TB] FAIL after_annul: got %h lat %0d expected %h lat 33", res, lat, {32'h0, 32'hFFFFFFFF}); end
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1 || result !== {32'h0, 32'hFFFFFFFF}) begin n_fail++; $display("[TB] FAIL annul_in_end: got ready=%b result=%h", ready, result); end
        @(negedge clk);
        annul = 1'b0;
        release_start();
        annul_run(32, seen);
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL annul_at_cnt32: got ready=1 expected never"); end
    endtask

    task automatic test_start_with_annul();
        bit seen = 1'b0;
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd999;
        opdata2    = 32'd5;
        start      = 1'b1;
        annul      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL start_and_annul: got ready=1 expected never"); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        @(negedge clk);
        signed_div = 1'b1;
        opdata1    = 32'hFFFF0000;
        opdata2    = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_mid: got ready=%b result=%h expected 0/0", ready, result); end
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b1, 32'hFFFF0000, 32'd3, 1'b0, res, lat);
        n_checks++;
        if (res !== model(1'b1, 32'hFFFF0000, 32'd3) || lat !== 33) begin n_fail++; $display("[TB] FAIL after_reset_mid: got %h lat %0d expected %h lat 33", res, lat, model(1'b1, 32'hFFFF0000, 32'd3)); end
        release_start();
    endtask

    task automatic test_operand_stability();
        logic [63:0] res;
        logic [31:0] a, b;
        logic sg;
        int lat;
        for (int i = 0; i < 5; i++) begin
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd1;
            sg = 1'($urandom_range(0, 1));
            run_div(sg, a, b, 1'b1, res, lat);
            n_checks++;
            if (res !== model(sg, a, b) || lat !== 33) begin n_fail++; $display("[TB] FAIL stability_%0d: got %h lat %0d expected %h lat 33", i, res, lat, model(sg, a, b)); end
            release_start();
        end
    endtask

    task automatic test_random();
        logic [63:0] res;
        logic [31:0] a, b;
        logic sg;
        int lat, exp_lat;
        for (int i = 0; i < 25; i++) begin
            a  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            exp_lat = (b == 32'd0) ? 2 : 33;
            run_div(sg, a, b, 1'b0, res, lat);
            n_checks++;
            if (res !== model(sg, a, b)) begin n_fail++; $display("[TB] FAIL random_%0d: sg=%b %h/%h got %h expected %h", i, sg, a, b, res, model(sg, a, b)); end
            n_checks++;
            if (lat !== exp_lat) begin n_fail++; $display("[TB] FAIL random_lat_%0d: got %0d expected %0d", i, lat, exp_lat); end
            release_start();
            n_checks++;
            if (ready !== 1'b0 || result !== 64'h0) begin n_fail++; $display("[TB] FAIL random_release_%0d: got ready=%b result=%h", i, ready, result); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_start_with_annul();
        test_reset_mid();
        test_operand_stability();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
